// File: rtl/vga_fb_arbiter.sv
// Shares one single-port 640x480x8 framebuffer between VGA scanout and a CPU port.
// Video slots always own the port; CPU accesses fill the remaining cycles and are acked one cycle later.
module vga_fb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_tick,
  input  logic        active,
  input  logic [9:0]  posx,
  input  logic [9:0]  posy,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel,
  output logic        state
);

  localparam logic S_IDLE     = 1'b0;
  localparam logic S_CPU_DONE = 1'b1;

  localparam logic [18:0] FB_SIZE = 19'd307200;

  // Handshake: cpu_req is held by the requester until cpu_ack; cpu_ack is a
  // single-cycle pulse, and cpu_rdata/cpu_err are only meaningful while it is high.

  logic        state_q;
  logic        state_d;
  logic        done_we_q;
  logic        done_err_q;
  logic        tick_d1;
  logic        slot_d1;
  logic [7:0]  pixel_q;
  logic        video_slot;
  logic        cpu_issue;
  logic        cpu_in_range;
  logic [18:0] video_addr;
  logic [18:0] posy_w;
  logic [18:0] posx_w;

  assign posy_w       = {9'd0, posy};
  assign posx_w       = {9'd0, posx};
  assign video_slot   = pix_tick && active && (posx < 10'd640) && (posy < 10'd480);
  assign video_addr   = (posy_w << 9) + (posy_w << 7) + posx_w;
  assign cpu_in_range = cpu_addr < FB_SIZE;
  assign cpu_issue    = !rst && (state_q == S_IDLE) && cpu_req && !video_slot;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 19'd0;
    mem_wdata = 8'd0;
    state_d   = state_q;
    if (!rst) begin
      if (video_slot) begin
        mem_en   = 1'b1;
        mem_addr = video_addr;
      end else if (cpu_issue && cpu_in_range) begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
    case (state_q)
      S_IDLE:     if (cpu_issue) state_d = S_CPU_DONE;
      S_CPU_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      done_we_q  <= 1'b0;
      done_err_q <= 1'b0;
      tick_d1    <= 1'b0;
      slot_d1    <= 1'b0;
      pixel_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      // Out-of-range requests still walk through CPU_DONE so the requester gets its ack.
      if (cpu_issue) begin
        done_we_q  <= cpu_we;
        done_err_q <= !cpu_in_range;
      end
      tick_d1 <= pix_tick;
      slot_d1 <= video_slot;
      if (tick_d1) pixel_q <= slot_d1 ? mem_rdata : 8'd0;
    end
  end

  assign cpu_ack   = !rst && (state_q == S_CPU_DONE);
  assign cpu_err   = cpu_ack && done_err_q;
  assign cpu_rdata = (cpu_ack && !done_we_q && !done_err_q) ? mem_rdata : 8'd0;
  assign pixel     = rst ? 8'd0 : pixel_q;
  assign state     = rst ? S_IDLE : state_q;

endmodule
